// File: rtl/mux4_1.sv
// 4:1 single-bit multiplexer with a combinational output and a registered copy.
// It also has a one-cycle change flag and a saturating count of output transitions.
module mux4_1 #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       s,
  input  logic             d0,
  input  logic             d1,
  input  logic             d2,
  input  logic             d3,
  output logic             y,
  output logic             y_q,
  output logic [1:0]       s_q,
  output logic             chg,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             y_d;
  logic [1:0]       s_d;
  logic             chg_d;
  logic             chg_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    y = d0;
    case (s)
      2'b00:   y = d0;
      2'b01:   y = d1;
      2'b10:   y = d2;
      2'b11:   y = d3;
      default: y = d0;
    endcase
  end

  // The transition is judged against the flop's current value, so the first
  // edge after reset compares y against the reset value 0.
  always_comb begin
    y_d   = y;
    s_d   = s;
    chg_d = (y != y_q);
    cnt_d = cnt_q;
    if (chg_d && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q   <= 1'b0;
      s_q   <= 2'b00;
      chg_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      y_q   <= y_d;
      s_q   <= s_d;
      chg_q <= chg_d;
      cnt_q <= cnt_d;
    end
  end

  assign chg = chg_q;
  assign cnt = cnt_q;

endmodule

// File: tb/tb_mux4_1.sv
// Directed bench for mux4_1. Expected values come from a reference model and
// pass through a scoreboard queue, then get compared with immediate assertions.
module tb_mux4_1;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [1:0]       s   = 2'b00;
  logic             d0  = 1'b0;
  logic             d1  = 1'b0;
  logic             d2  = 1'b0;
  logic             d3  = 1'b0;
  logic             y;
  logic             y_q;
  logic [1:0]       s_q;
  logic             chg;
  logic [CNT_W-1:0] cnt;

  mux4_1 #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .s   (s),
    .d0  (d0),
    .d1  (d1),
    .d2  (d2),
    .d3  (d3),
    .y   (y),
    .y_q (y_q),
    .s_q (s_q),
    .chg (chg),
    .cnt (cnt)
  );

  always #5 clk = ~clk;

  logic [31:0] sb_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model state
  logic       m_yq;
  logic [1:0] m_sq;
  logic       m_chg;
  int         m_cnt;

  function automatic logic ref_y(input logic [1:0] sel, input logic [3:0] dv);
    return dv[sel];
  endfunction

  function automatic logic cur_ref_y();
    return ref_y(s, {d3, d2, d1, d0});
  endfunction

  task automatic expect_val(input logic [31:0] v);
    sb_q.push_back(v);
  endtask

  task automatic compare(input string tag, input logic [31:0] obs);
    logic [31:0] exp_v;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $error("FAIL %s: scoreboard empty, observed %0h", tag, obs);
    end else begin
      exp_v = sb_q.pop_front();
      assert (obs === exp_v)
      else begin
        bad++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
    end
  endtask

  task automatic drive(input logic [1:0] sel, input logic [3:0] dv);
    s = sel;
    {d3, d2, d1, d0} = dv;
  endtask

  task automatic check_y(input string tag);
    expect_val({31'd0, cur_ref_y()});
    #1;
    compare(tag, {31'd0, y});
  endtask

  task automatic check_regs(input string tag);
    expect_val({31'd0, m_yq});
    expect_val({30'd0, m_sq});
    expect_val({31'd0, m_chg});
    expect_val(32'(m_cnt));
    compare({tag, ".y_q"}, {31'd0, y_q});
    compare({tag, ".s_q"}, {30'd0, s_q});
    compare({tag, ".chg"}, {31'd0, chg});
    compare({tag, ".cnt"}, 32'(cnt));
  endtask

  task automatic model_reset();
    m_yq  = 1'b0;
    m_sq  = 2'b00;
    m_chg = 1'b0;
    m_cnt = 0;
  endtask

  // Inputs are stable around the edge, so the model samples them right at it.
  task automatic tick(input string tag);
    logic ym;
    @(posedge clk);
    ym    = cur_ref_y();
    m_chg = (ym != m_yq);
    if (m_chg && (m_cnt != CNT_MAX)) m_cnt++;
    m_yq  = ym;
    m_sq  = s;
    #1;
    check_regs(tag);
  endtask

  initial begin
    logic [5:0] v;

    // Asynchronous reset with no clock edge yet
    #1 rst = 1'b1;
    model_reset();
    #1;
    check_regs("reset_async");

    // Exhaustive combinational check, done while reset is held
    for (int i = 0; i < 64; i++) begin
      v = i[5:0];
      {s, d0, d1, d2, d3} = v;
      check_y($sformatf("exh_%0d", i));
    end
    check_regs("reset_hold");

    // Unselected inputs must not disturb y
    drive(2'b10, 4'b0100);
    check_y("sel2_base");
    d0 = 1'b1; check_y("sel2_d0");
    d1 = 1'b1; check_y("sel2_d1");
    d3 = 1'b1; check_y("sel2_d3");
    d0 = 1'b0; d1 = 1'b0; d3 = 1'b0; check_y("sel2_others_low");
    d2 = 1'b0; check_y("sel2_d2_low");

    // First edges after reset release
    @(negedge clk);
    rst = 1'b0;
    drive(2'b11, 4'b1000);
    tick("first_edge");
    tick("second_edge");

    // Toggle the selected input every cycle until the counter saturates
    for (int i = 0; i < 300; i++) begin
      d3 = ~d3;
      tick($sformatf("toggle_%0d", i));
    end
    expect_val(32'(CNT_MAX));
    compare("cnt_saturated", 32'(cnt));
    d3 = ~d3; tick("sat_hold_a");
    d3 = ~d3; tick("sat_hold_b");

    // Asynchronous reset between edges with the counter saturated
    #3 rst = 1'b1;
    model_reset();
    #1;
    check_regs("reset_mid");
    check_y("reset_mid_y");
    d3 = 1'b0;
    check_y("reset_mid_y_track");
    @(posedge clk);
    #1;
    check_regs("reset_mid_hold");

    // Resume with other selects and random data
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 24; i++) begin
      drive(2'(i % 4), 4'($urandom_range(0, 15)));
      check_y($sformatf("resume_y_%0d", i));
      tick($sformatf("resume_%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux4_1.md
MUX4_1 -- requirements
Module: mux4_1

Interface
REQ-001 Parameter: CNT_W, default 8, width of the output-transition counter (legal range 2..16).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: s  input  2  select; s[1] is MSB.
REQ-005 Port: d0  input  1  data input chosen when s=2'b00.
REQ-006 Port: d1  input  1  data input chosen when s=2'b01.
REQ-007 Port: d2  input  1  data input chosen when s=2'b10.
REQ-008 Port: d3  input  1  data input chosen when s=2'b11.
REQ-009 Port: y  output  1  combinational mux output.
REQ-010 Port: y_q  output  1  registered copy of y.
REQ-011 Port: s_q  output  2  registered copy of s.
REQ-012 Port: chg  output  1  one-cycle flag; registered output changed value.
REQ-013 Port: cnt  output  CNT_W  saturating count of registered output transitions.

Function
REQ-014 y SHALL equal d0/d1/d2/d3 for s = 00/01/10/11 respectively, purely combinationally, zero cycles latency.
REQ-015 y SHALL be independent of clk and rst; it follows s and d* at all times, including during reset.
REQ-016 Any change on s or the selected d* SHALL propagate to y within the same delta/settle time; unselected inputs SHALL NOT affect y.
REQ-017 Each rising clk edge with rst=0: y_q <= y, s_q <= s (one-cycle latency).
REQ-018 Each rising clk edge with rst=0: chg <= 1 if y differs from the current y_q, else 0.
REQ-019 Each rising clk edge with rst=0 where y differs from current y_q: cnt <= cnt+1, saturating at all-ones (2^CNT_W-1); otherwise cnt holds.
REQ-020 cnt SHALL never wrap; once saturated it holds until reset.
REQ-021 The first edge after reset release SHALL compare y against the reset value y_q=0 (y=1 counts as a transition).
REQ-022 All registered outputs SHALL be driven only by flops; no combinational path from inputs to y_q, s_q, chg, cnt.

Reset
REQ-023 rst=1 SHALL immediately (asynchronously, no clock required) force y_q=0, s_q=2'b00, chg=0, cnt=0.
REQ-024 While rst=1 registered outputs SHALL hold reset values regardless of clk and inputs.
REQ-025 Reset asserted mid-operation (including while cnt saturated) SHALL clear all state in the same way; y keeps tracking inputs.
REQ-026 Deassertion of rst SHALL take effect synchronously: first state update on the first rising clk edge with rst=0.

Verification
REQ-027 Exhaustive: all 64 combinations of {s,d0,d1,d2,d3} -> y equals selected input every time, zero mismatches.
REQ-028 s=2'b10, d2=1, others 0, then toggle d0,d1,d3 -> y stays 1; flip d2 to 0 -> y=0 immediately.
REQ-029 Reset release, s=2'b11, d3=1, one clock -> y_q=1, s_q=2'b11, chg=1, cnt=1; next clock same inputs -> chg=0, cnt=1.
REQ-030 Toggle selected input every cycle for 300 cycles with CNT_W=8 -> cnt reaches 255 and holds at 255.
REQ-031 Assert rst asynchronously between clock edges with cnt=255, y_q=1 -> y_q=0, s_q=00, chg=0, cnt=0 before next edge; y still equals selected input.
